instr_fetch: RTL
================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter: PC_W, default 10, program counter / instruction-memory address width.
REQ-002 Clock and reset: one clock; reset is synchronous and active-low. Clk  in  1  rising-edge clock.
REQ-003 Reset_n  in  1  synchronous active-low reset.
REQ-004 Start  in  1  one-cycle pulse; starts program execution at address 0.
REQ-005 Halt  in  1  halt request from the decoder for the current instruction.
REQ-006 Jump_en  in  1  jump request from the decoder for the current instruction.
REQ-007 Branch_flag  in  1  condition flag; a jump is taken only when this is 1.
REQ-008 Jump_address  in  5  index into the jump-target table.
REQ-009 Lut_we  in  1  jump-target table write enable.
REQ-010 Lut_waddr  in  5  jump-target table write index.
REQ-011 Lut_wdata  in  PC_W  jump-target table write data.
REQ-012 Inst_data  in  9  instruction word returned by the asynchronous instruction memory.
REQ-013 Inst_addr  out  PC_W  instruction-memory address; equals PC, combinational.
REQ-014 Instruction  out  9  instruction presented to the decoder.
REQ-015 Running  out  1  high in RUN.
REQ-016 Done  out  1  high in HALTED.
REQ-017 Cycle_count  out  16  count of instructions executed (present only with CYCLE_COUNT_EN).

Function
REQ-018 Three-state FSM: IDLE, RUN, HALTED. All state, PC, table and counter updates occur on the rising Clk edge.
REQ-019 IDLE: Start=1 moves the FSM to RUN with PC=0. Otherwise the FSM holds IDLE with PC=0.
REQ-020 RUN: Halt=1 moves the FSM to HALTED and holds PC. Halt has priority over Jump_en.
REQ-021 RUN, no halt, Jump_en=1 and Branch_flag=1: next PC = LUT[Jump_address].
REQ-022 RUN, all other cases: next PC = PC+1, wrapping from 2^PC_W-1 to 0.
REQ-023 RUN: Start is ignored.
REQ-024 HALTED: Start=1 moves the FSM to RUN with PC=0. Otherwise the FSM holds HALTED and PC is frozen.
REQ-025 Instruction output:
- In RUN, Instruction = Inst_data.
- In IDLE and HALTED, Instruction is forced to 9'b000000011 (halt encoding), so the downstream decoder issues no register or memory writes.
REQ-026 Jump-target table: 32 entries of PC_W bits. Write is synchronous when Lut_we=1 and is accepted in every state.
REQ-027 Table read is combinational. A write and a read of the same entry in the same cycle returns the old value; the new value is visible from the next cycle.
REQ-028 Done and Running are decoded from the registered state; they never change within a cycle.

Reset
REQ-029 Reset_n=0 at a clock edge, including mid-RUN:
- state = IDLE, PC = 0;
- all 32 table entries = 0;
- Cycle_count = 0.
Reset has priority over Start, Halt and Lut_we.
REQ-030 Outputs after reset: Inst_addr=0, Instruction=9'b000000011, Running=0, Done=0.

Configuration
REQ-031 Macro CYCLE_COUNT_EN, when defined:
- Cycle_count increments by 1 on every clock edge taken in RUN, including the halt cycle.
- It saturates at 16'hFFFF.
- It is cleared to 0 on reset and on any accepted Start.
- It holds its value in IDLE and HALTED.
REQ-032 Without CYCLE_COUNT_EN, the Cycle_count port and the counter logic are absent. All other behaviour is identical.

Verification
REQ-033 Reset, then Start pulse, Inst_data=9'b001000000 constant, 4 cycles -> Inst_addr steps 0,1,2,3; Running=1; Cycle_count=4.
REQ-034 Write LUT[5]=10'd200, then in RUN with Jump_en=1, Jump_address=5, Branch_flag=1 -> next Inst_addr=200; repeat with Branch_flag=0 -> next Inst_addr=201.
REQ-035 Halt=1 at PC=7 -> PC stays 7, Done=1, Instruction=9'b000000011 next cycle, Cycle_count frozen at 8; Halt=1 and Jump_en=1 together -> halt wins.
REQ-036 Load LUT[1]=1023 and jump there, no further jumps -> PC sequence 1023,0,1 (wrap-around).
REQ-037 Reset_n=0 mid-RUN at PC=50 -> next cycle PC=0, IDLE, LUT[1] reads 0, Cycle_count=0; Start while HALTED -> RUN from PC=0, counter cleared.
REQ-038 Lut_we=1 on index 3 with data 99 while jumping via index 3 (old value 40) -> jump target 40; a later jump via index 3 -> target 99.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch unit: program counter, three-state run control and a
// 32-entry jump-target table.
//
// Optional feature: define CYCLE_COUNT_EN to add the o_cycle_count port and a
// saturating counter of instructions executed in RUN.
//
// Ports:
//   i_clk           rising-edge clock
//   i_reset_n       synchronous active-low reset
//   i_start         one-cycle pulse, starts execution at address 0
//   i_halt          halt request for the current instruction
//   i_jump_en       jump request for the current instruction
//   i_branch_flag   jump is taken only when this is 1
//   i_jump_address  jump-target table read index
//   i_lut_we        jump-target table write enable
//   i_lut_waddr     jump-target table write index
//   i_lut_wdata     jump-target table write data
//   i_inst_data     instruction word from asynchronous instruction memory
//   o_inst_addr     instruction-memory address (the PC)
//   o_instruction   instruction presented to the decoder
//   o_cycle_count   instructions executed (CYCLE_COUNT_EN only)
//   o_running       high in RUN
//   o_done          high in HALTED
module instr_fetch #(
  parameter int unsigned PC_W = 10
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_start,
  input  logic            i_halt,
  input  logic            i_jump_en,
  input  logic            i_branch_flag,
  input  logic [4:0]      i_jump_address,
  input  logic            i_lut_we,
  input  logic [4:0]      i_lut_waddr,
  input  logic [PC_W-1:0] i_lut_wdata,
  input  logic [8:0]      i_inst_data,
  output logic [PC_W-1:0] o_inst_addr,
  output logic [8:0]      o_instruction,
  output logic            o_running,
`ifdef CYCLE_COUNT_EN
  output logic [15:0]     o_cycle_count,
`endif
  output logic            o_done
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  // Halt encoding: the decoder issues no register or memory writes for it.
  localparam logic [8:0] HALT_INSTR = 9'b000000011;

  logic [1:0]      r_state;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] r_lut [32];

  logic [1:0]      w_state_next;
  logic [PC_W-1:0] w_pc_next;
  logic [PC_W-1:0] w_lut_rdata;

  // Combinational read sees the pre-write contents on a same-cycle write.
  assign w_lut_rdata = r_lut[i_jump_address];

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    case (r_state)
      ST_IDLE: begin
        w_pc_next = '0;
        if (i_start) w_state_next = ST_RUN;
      end
      ST_RUN: begin
        // Halt wins over a jump; Start is ignored here.
        if (i_halt) begin
          w_state_next = ST_HALTED;
        end else if (i_jump_en && i_branch_flag) begin
          w_pc_next = w_lut_rdata;
        end else begin
          w_pc_next = r_pc + PC_W'(1);
        end
      end
      ST_HALTED: begin
        if (i_start) begin
          w_state_next = ST_RUN;
          w_pc_next    = '0;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_pc_next    = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
      r_pc    <= '0;
      for (int i = 0; i < 32; i++) begin
        r_lut[i] <= '0;
      end
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      if (i_lut_we) r_lut[i_lut_waddr] <= i_lut_wdata;
    end
  end

`ifdef CYCLE_COUNT_EN
  logic        w_start_accept;
  logic [15:0] r_cycle_count;

  assign w_start_accept = i_start && (r_state != ST_RUN);

  // Counts every edge taken in RUN, halt cycle included; saturates.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_cycle_count <= '0;
    end else if (w_start_accept) begin
      r_cycle_count <= '0;
    end else if (r_state == ST_RUN && r_cycle_count != 16'hFFFF) begin
      r_cycle_count <= r_cycle_count + 16'd1;
    end
  end

  assign o_cycle_count = r_cycle_count;
`endif

  assign o_inst_addr   = r_pc;
  assign o_instruction = (r_state == ST_RUN) ? i_inst_data : HALT_INSTR;
  assign o_running     = (r_state == ST_RUN);
  assign o_done        = (r_state == ST_HALTED);

endmodule
